// File: rtl/rvfi_order_buffer.sv
// rvfi_order_buffer: reorders out-of-order RVFI retirements into a strictly
// increasing stream, one per cycle, flagging out-of-window and duplicate arrivals.
module rvfi_order_buffer #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            in_valid,
   input  logic [63:0]     in_order,
   input  logic [4:0]      in_rs1_addr,
   input  logic [4:0]      in_rs2_addr,
   input  logic [4:0]      in_rd_addr,
   input  logic [XLEN-1:0] in_rs1_rdata,
   input  logic [XLEN-1:0] in_rs2_rdata,
   input  logic [XLEN-1:0] in_rd_wdata,
   output logic            out_valid,
   output logic [63:0]     out_order,
   output logic [4:0]      out_rs1_addr,
   output logic [4:0]      out_rs2_addr,
   output logic [4:0]      out_rd_addr,
   output logic [XLEN-1:0] out_rs1_rdata,
   output logic [XLEN-1:0] out_rs2_rdata,
   output logic [XLEN-1:0] out_rd_wdata,
   output logic            err_window,
   output logic            err_dup,
   output logic [AW:0]     pending
);
   localparam int RW = 15 + 3 * XLEN;

   logic [RW-1:0]    mem_q [DEPTH];
   logic [DEPTH-1:0] full_q, full_d;
   logic [63:0]      head_q, head_d;
   logic [AW:0]      pending_q, pending_d;
   logic [RW-1:0]    out_rec_q, out_rec_d;
   logic [63:0]      out_order_q, out_order_d;
   logic             out_valid_q, out_valid_d;
   logic             err_window_q, err_window_d;
   logic             err_dup_q, err_dup_d;
   logic [RW-1:0]    in_rec;
   logic [AW-1:0]    wslot, hslot;
   logic             in_win, drain, accept;

   assign in_rec = {in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_rdata, in_rs2_rdata, in_rd_wdata};
   assign wslot  = in_order[AW-1:0];
   assign hslot  = head_q[AW-1:0];
   // Distance form of head <= order <= head+DEPTH-1 never overflows near 2^64
   assign in_win = (in_order >= head_q) && ((in_order - head_q) < 64'(DEPTH));
   assign drain  = full_q[hslot];
   assign accept = in_valid && in_win && !full_q[wslot];

   always_comb begin
      full_d = full_q;
      if (drain) full_d[hslot] = 1'b0;
      if (accept) full_d[wslot] = 1'b1;
      head_d       = head_q + {63'd0, drain};
      pending_d    = pending_q + {{AW{1'b0}}, accept} - {{AW{1'b0}}, drain};
      out_valid_d  = drain;
      out_rec_d    = drain ? mem_q[hslot] : out_rec_q;
      out_order_d  = drain ? head_q : out_order_q;
      err_window_d = err_window_q | (in_valid & ~in_win);
      err_dup_d    = err_dup_q | (in_valid & in_win & full_q[wslot]);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         full_q       <= '0;
         head_q       <= '0;
         pending_q    <= '0;
         out_valid_q  <= 1'b0;
         out_rec_q    <= '0;
         out_order_q  <= '0;
         err_window_q <= 1'b0;
         err_dup_q    <= 1'b0;
      end else begin
         full_q       <= full_d;
         head_q       <= head_d;
         pending_q    <= pending_d;
         out_valid_q  <= out_valid_d;
         out_rec_q    <= out_rec_d;
         out_order_q  <= out_order_d;
         err_window_q <= err_window_d;
         err_dup_q    <= err_dup_d;
      end
   end

   // Record storage needs no reset: full flags alone decide what is live
   always_ff @(posedge clock) begin
      if (resetn && accept) mem_q[wslot] <= in_rec;
   end

   assign {out_rs1_addr, out_rs2_addr, out_rd_addr, out_rs1_rdata, out_rs2_rdata, out_rd_wdata} = out_rec_q;
   assign out_valid  = out_valid_q;
   assign out_order  = out_order_q;
   assign err_window = err_window_q;
   assign err_dup    = err_dup_q;
   assign pending    = pending_q;
endmodule
